bin2bcd_iter: RTL and testbench

BIN2BCD_ITER -- requirements
Module: bin2bcd_iter

---
 rtl/bin2bcd_iter.sv | 89 ++++++++
 tb/tb_bin2bcd_iter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_iter.sv
// bin2bcd_iter: iterative double-dabble binary-to-BCD converter with valid/ready handshakes.
// Saturates to all nines and flags overflow when the value needs more than DIGITS digits.
module bin2bcd_iter #(
  parameter int BIN_W  = 30,
  parameter int DIGITS = 9
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIN_W-1:0]             bin_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          bcd_data,
  output logic                         overflow,
  output logic [$clog2(DIGITS+1)-1:0]  ndigits
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int NW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d, adj;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    unique case (state_q)
      IDLE: if (in_valid) begin
        bin_d   = bin_data;
        bcd_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = CW'(BIN_W);
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d   = {adj[BW-2:0], bin_q[BIN_W-1]};
        bin_d   = bin_q << 1;
        ovf_d   = ovf_q | adj[BW-1];
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? DONE : SHIFT;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bcd_data = ovf_q ? {DIGITS{4'h9}} : bcd_q;
  assign overflow = ovf_q;

  // Zero reads as one significant digit; saturated output reports all digits.
  always_comb begin
    ndigits = NW'(1);
    for (int i = 0; i < DIGITS; i++)
      if (bcd_data[4*i +: 4] != 4'd0) ndigits = NW'(i + 1);
  end
endmodule

// File: tb/tb_bin2bcd_iter.sv
// tb_bin2bcd_iter: table-driven check of bin2bcd_iter at default and narrow parameters.
module tb_bin2bcd_iter;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        iv_a, ir_a, ov_a, or_a, ovf_a;
  logic [29:0] bin_a;
  logic [35:0] bcd_a;
  logic [3:0]  nd_a;
  logic        iv_b, ir_b, ov_b, or_b, ovf_b;
  logic [7:0]  bin_b;
  logic [7:0]  bcd_b;
  logic [1:0]  nd_b;
  int n_chk = 0;
  int n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  bin2bcd_iter dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_valid(iv_a), .in_ready(ir_a),
    .bin_data(bin_a), .out_valid(ov_a), .out_ready(or_a), .bcd_data(bcd_a),
    .overflow(ovf_a), .ndigits(nd_a)
  );

  bin2bcd_iter #(.BIN_W(8), .DIGITS(2)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_valid(iv_b), .in_ready(ir_b),
    .bin_data(bin_b), .out_valid(ov_b), .out_ready(or_b), .bcd_data(bcd_b),
    .overflow(ovf_b), .ndigits(nd_b)
  );

  typedef struct {
    logic [29:0] bin;
    logic [35:0] bcd;
    logic        ovf;
    logic [3:0]  nd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ov_a(output int lat);
    lat = 0;
    while (!ov_a && lat < 100) begin
      @(posedge sys_clk); #1;
      lat++;
    end
  endtask

  task automatic conv_a(input string nm, input logic [29:0] v, input logic [35:0] eb,
                        input logic eo, input logic [3:0] en);
    int lat;
    iv_a = 1'b1; bin_a = v;
    chk({nm, " in_ready idle"}, 64'(ir_a), 64'd1);
    @(posedge sys_clk); #1;
    iv_a = 1'b0; bin_a = '1;
    chk({nm, " in_ready busy"}, 64'(ir_a), 64'd0);
    wait_ov_a(lat);
    chk({nm, " latency"}, 64'(lat), 64'd30);
    chk({nm, " bcd"}, 64'(bcd_a), 64'(eb));
    chk({nm, " ovf"}, 64'(ovf_a), 64'(eo));
    chk({nm, " nd"}, 64'(nd_a), 64'(en));
    @(posedge sys_clk); #1;
    chk({nm, " released"}, 64'(ov_a), 64'd0);
  endtask

  task automatic conv_b(input string nm, input logic [7:0] v, input logic [7:0] eb,
                        input logic eo, input logic [1:0] en);
    int lat;
    iv_b = 1'b1; bin_b = v;
    @(posedge sys_clk); #1;
    iv_b = 1'b0; bin_b = 8'h5a;
    lat = 0;
    while (!ov_b && lat < 100) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd8);
    chk({nm, " bcd"}, 64'(bcd_b), 64'(eb));
    chk({nm, " ovf"}, 64'(ovf_b), 64'(eo));
    chk({nm, " nd"}, 64'(nd_b), 64'(en));
    @(posedge sys_clk); #1;
  endtask

  initial begin
    int lat;
    vecs[0]  = '{30'd19,         36'h000000019, 1'b0, 4'd2};
    vecs[1]  = '{30'd999999999,  36'h999999999, 1'b0, 4'd9};
    vecs[2]  = '{30'd0,          36'h000000000, 1'b0, 4'd1};
    vecs[3]  = '{30'd1000000000, 36'h999999999, 1'b1, 4'd9};
    vecs[4]  = '{30'd5,          36'h000000005, 1'b0, 4'd1};
    vecs[5]  = '{30'd123456789,  36'h123456789, 1'b0, 4'd9};
    vecs[6]  = '{30'd1073741823, 36'h999999999, 1'b1, 4'd9};
    vecs[7]  = '{30'd100,        36'h000000100, 1'b0, 4'd3};
    vecs[8]  = '{30'd9,          36'h000000009, 1'b0, 4'd1};
    vecs[9]  = '{30'd10,         36'h000000010, 1'b0, 4'd2};
    vecs[10] = '{30'd80000001,   36'h080000001, 1'b0, 4'd8};
    vecs[11] = '{30'd4096,       36'h000004096, 1'b0, 4'd4};

    sys_rst_n = 1'b0;
    iv_a = 1'b0; bin_a = '0; or_a = 1'b1;
    iv_b = 1'b0; bin_b = '0; or_b = 1'b1;
    #2;
    chk("reset in_ready", 64'(ir_a), 64'd1);
    chk("reset out_valid", 64'(ov_a), 64'd0);
    chk("reset bcd", 64'(bcd_a), 64'd0);
    chk("reset ovf", 64'(ovf_a), 64'd0);
    chk("reset nd", 64'(nd_a), 64'd1);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      conv_a($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf, vecs[i].nd);

    // Backpressure with in_valid held high throughout.
    or_a = 1'b0; iv_a = 1'b1; bin_a = 30'd77;
    @(posedge sys_clk); #1;
    bin_a = 30'd555;
    wait_ov_a(lat);
    chk("bp latency", 64'(lat), 64'd30);
    for (int k = 0; k < 5; k++) begin
      @(posedge sys_clk); #1;
      chk("bp hold valid", 64'(ov_a), 64'd1);
      chk("bp hold ready", 64'(ir_a), 64'd0);
      chk("bp hold bcd", 64'(bcd_a), 64'h77);
      chk("bp hold nd", 64'(nd_a), 64'd2);
    end
    or_a = 1'b1;
    @(posedge sys_clk); #1;
    chk("bp idle ready", 64'(ir_a), 64'd1);
    chk("bp idle valid", 64'(ov_a), 64'd0);
    @(posedge sys_clk); #1;
    chk("bp accepted", 64'(ir_a), 64'd0);
    iv_a = 1'b0;
    wait_ov_a(lat);
    chk("bp second latency", 64'(lat), 64'd30);
    chk("bp second bcd", 64'(bcd_a), 64'h555);
    @(posedge sys_clk); #1;

    // Reset mid-conversion aborts with no result.
    iv_a = 1'b1; bin_a = 30'd12345;
    @(posedge sys_clk); #1;
    iv_a = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("abort in_ready", 64'(ir_a), 64'd1);
    chk("abort out_valid", 64'(ov_a), 64'd0);
    chk("abort bcd", 64'(bcd_a), 64'd0);
    chk("abort ovf", 64'(ovf_a), 64'd0);
    chk("abort nd", 64'(nd_a), 64'd1);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    conv_a("post reset 42", 30'd42, 36'h42, 1'b0, 4'd2);

    conv_b("b255", 8'd255, 8'h99, 1'b1, 2'd2);
    conv_b("b99", 8'd99, 8'h99, 1'b0, 2'd2);
    conv_b("b7", 8'd7, 8'h07, 1'b0, 2'd1);
    conv_b("b100", 8'd100, 8'h99, 1'b1, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
